csr_unit_m: RTL and testbench
=============================

# csr_unit_m

Machine-mode control/status register unit for the 32-bit pipelined CPU, succeeding the fixed CSR block. Adds parametrised 64-bit cycle/instret counters, a registered mcause, set/clear CSR operations, timer and external interrupt sampling, and a WFI sleep state machine. Sits beside the EX/MEM stage: the pipeline reads and writes CSRs and retires instructions through it, and it tells the PC unit when and where to redirect for trap entry and mret.

## Interface
- MTVEC_INIT, 32'h0001_0000: reset value of mtvec; low 2 bits forced 0 (direct mode).
- MTVEC_WR, 0: 1 = mtvec writable by CSR ops; 0 = mtvec read-only at MTVEC_INIT.
- CNT_W, 64: implemented counter width, legal range 33..64.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- csr_addr  in  12  CSR address for read and write.
- csr_rdata  out  32  combinational read data for csr_addr.
- csr_wdata  in  32  operand for the CSR op.
- csr_op  in  2  00 none, 01 write, 10 set (OR), 11 clear (AND-NOT).
- retire  in  1  one instruction retires this cycle.
- stall  in  1  pipeline held; blocks all architectural updates except mcycle.
- wfi  in  1  WFI instruction in the commit slot.
- mret  in  1  MRET instruction in the commit slot.
- trap_pc  in  32  PC saved to mepc on interrupt entry.
- ext_irq  in  1  external interrupt, level.
- timer_irq  in  1  timer interrupt, level.
- redirect  out  1  fetch redirect this cycle.
- redirect_pc  out  32  target when redirect=1.
- sleeping  out  1  core is in WFI sleep.

## Operation
- Address map: mstatus 300, mie 304, mtvec 305, mepc 341, mcause 342, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82. Any other address reads 0, and writes to it are ignored.
- mstatus: MIE[3], MPIE[7], MPP[12:11]. MPP is hardwired to 2'b11, so writes to it are ignored. mie: MTIE[7], MEIE[11]. mip is read-only: MTIP[7], MEIP[11]. All unlisted bits read 0.
- A CSR op commits when csr_op≠00, stall=0 and no interrupt is taken. The new value is the old value combined with csr_wdata through write/set/clear. For mepc, bits [1:0] are forced to 0.
- MEIP and MTIP are flops loaded from ext_irq and timer_irq every cycle.
- pend = (MEIP&MEIE) | (MTIP&MTIE). An interrupt is taken when MIE & pend & stall=0.
- Interrupt entry:
  - mepc←trap_pc, MPIE←MIE, MIE←0.
  - mcause←32'h8000_000B if MEIP&MEIE, else 32'h8000_0007 (external has priority).
  - redirect=1, redirect_pc=mtvec.
- mret with stall=0 and no interrupt taken: MIE←MPIE, MPIE←1, redirect=1, redirect_pc=mepc.
- Priority in the same cycle: interrupt > mret > CSR op. The losing actions are discarded.
- FSM states:
  - RUN → SLEEP on wfi & stall=0 & pend=0. If pend=1, WFI acts as a no-op.
  - SLEEP → RUN when pend=1. Exit happens whether or not MIE is set. If MIE=1, the interrupt is taken in the exit cycle; otherwise execution resumes with no redirect.
  - sleeping=1 only in SLEEP. CSR ops and retire are ignored in SLEEP.
- mcycle increments every cycle.
- minstret increments on retire & stall=0.
- A CSR write to either counter half overrides that half's increment in the same cycle.
- Counters wrap at 2^CNT_W. Bits ≥ CNT_W read 0 and ignore writes.

## Timing
- Reset values:
  - csr_rdata follows the address map. After reset, mtvec reads MTVEC_INIT; every other register, counters included, reads 0 (MPP reads 11).
  - redirect=0, redirect_pc=mtvec, sleeping=0.
  - All registers 0 except mtvec=MTVEC_INIT and MPP=11. FSM starts in RUN.
- csr_rdata is combinational, same cycle as csr_addr. A written value is visible from the next cycle.
- redirect and redirect_pc are combinational from registered state and the commit inputs. The associated state updates land on the edge that ends the redirect cycle.
- Interrupt latency: ext_irq rises before edge N, MEIP is set at edge N, and redirect is asserted in the cycle after edge N, provided enabled and stall=0.
- stall=1 holds the take decision pending. It is re-evaluated every cycle.
- Reset asserted mid-operation immediately forces RUN and all reset values, including during SLEEP.

## Configuration
- CSR_COUNTERS_EN defined: mcycle, minstret, mcycleh and minstreth are implemented as above.
- CSR_COUNTERS_EN undefined: no counter flops are synthesised. The four counter addresses read 0 and ignore writes. CNT_W is unused.

## Test plan
- Reset, then read 305 → 32'h0001_0000. Read 300 → 32'h0000_1800. mcycle reads 1 at the first cycle after reset release.
- Write 304=32'h800 and 300=32'h8, then pulse ext_irq with trap_pc=32'h120 → redirect=1, redirect_pc=32'h0001_0000, then mepc=32'h120, mcause=32'h8000_000B, mstatus=32'h0000_1880.
- After the previous scenario, issue mret → redirect_pc=32'h120 and mstatus=32'h0000_1888.
- MIE=0, MTIE=1, wfi pulse → sleeping=1. Raise timer_irq → sleeping=0 two cycles later, with no redirect.
- Set {mcycleh, mcycle} to 32'h0/32'hFFFF_FFFF → next cycle mcycleh=1, mcycle=0. With CNT_W=40, writing mcycleh=32'hFFFF_FFFF reads back 32'h0000_00FF.
- Same cycle: timer interrupt taken, mret, and a write of 304 → only trap entry occurs, and mie is unchanged.

Source files
------------

// File: rtl/csr_unit_m_if.sv
// csr_unit_m_if: pipeline <-> CSR unit bus.
// The master (pipeline) drives the CSR access fields, commit strobes and interrupt lines.
// The slave (CSR unit) drives the read data, the redirect and the sleep status.
interface csr_unit_m_if;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic        retire;
  logic        stall;
  logic        wfi;
  logic        mret;
  logic [31:0] trap_pc;
  logic        ext_irq;
  logic        timer_irq;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        sleeping;
  modport master (
    output csr_addr, csr_wdata, csr_op, retire, stall, wfi, mret, trap_pc, ext_irq, timer_irq,
    input  csr_rdata, redirect, redirect_pc, sleeping
  );
  modport slave (
    input  csr_addr, csr_wdata, csr_op, retire, stall, wfi, mret, trap_pc, ext_irq, timer_irq,
    output csr_rdata, redirect, redirect_pc, sleeping
  );
endinterface

// File: rtl/csr_unit_m.sv
// csr_unit_m: machine-mode CSRs, interrupt entry/mret redirect, WFI sleep FSM, optional cycle/instret counters.
// Ports: clk_i clock; rst_ni async active-low reset; bus (csr_unit_m_if.slave) CSR access, commit strobes,
// interrupt lines, redirect and sleep status.
// Define CSR_COUNTERS_EN to build mcycle/minstret (CNT_W bits wide); otherwise the counter addresses read 0.
module csr_unit_m #(
  parameter logic [31:0] MTVEC_INIT = 32'h0001_0000,
  parameter bit          MTVEC_WR   = 1'b0,
  parameter int          CNT_W      = 64
) (
  input logic         clk_i,
  input logic         rst_ni,
  csr_unit_m_if.slave bus
);
  typedef enum logic {RUN, SLEEP} state_e;
  state_e state_q, state_d;
  logic mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d, meie_q, meie_d, mtip_q, meip_q;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mtvec, rdata, wval;
  logic [63:0] cyc64, ins64;
  logic pend, take, do_mret, csr_we;
  assign mtvec   = MTVEC_WR ? mtvec_q : {MTVEC_INIT[31:2], 2'b00};
  assign pend    = (meip_q & meie_q) | (mtip_q & mtie_q);
  assign take    = mie_q & pend & ~bus.stall;
  assign do_mret = bus.mret & ~bus.stall & ~take;
  // trap entry and mret both beat a CSR op in the same cycle; sleep blocks CSR ops
  assign csr_we  = (bus.csr_op != 2'b00) & ~bus.stall & ~take & ~bus.mret & (state_q == RUN);
  assign wval    = bus.csr_op == 2'b01 ? bus.csr_wdata :
                   bus.csr_op == 2'b10 ? rdata | bus.csr_wdata : rdata & ~bus.csr_wdata;
  assign bus.csr_rdata   = rdata;
  assign bus.redirect    = take | do_mret;
  assign bus.redirect_pc = do_mret ? mepc_q : mtvec;
  assign bus.sleeping    = state_q == SLEEP;
  always_comb begin
    rdata = '0;
    case (bus.csr_addr)
      12'h300: rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h304: rdata = {20'd0, meie_q, 3'd0, mtie_q, 7'd0};
      12'h305: rdata = mtvec;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};
      12'hB00: rdata = cyc64[31:0];
      12'hB02: rdata = ins64[31:0];
      12'hB80: rdata = cyc64[63:32];
      12'hB82: rdata = ins64[63:32];
      default: rdata = '0;
    endcase
  end
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (take) begin
      mepc_d   = {bus.trap_pc[31:2], 2'b00};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = (meip_q & meie_q) ? 32'h8000_000B : 32'h8000_0007;
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr)
        12'h300: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        12'h304: begin
          mtie_d = wval[7];
          meie_d = wval[11];
        end
        12'h305: mtvec_d  = MTVEC_WR ? {wval[31:2], 2'b00} : mtvec_q;
        12'h341: mepc_d   = {wval[31:2], 2'b00};
        12'h342: mcause_d = wval;
        default: ;
      endcase
    end
  end
  // wake-up ignores MIE; if MIE is set, take fires in the same exit cycle
  always_comb begin
    state_d = state_q == RUN ? ((bus.wfi & ~bus.stall & ~pend) ? SLEEP : RUN) : (pend ? RUN : SLEEP);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtip_q   <= 1'b0;
      meip_q   <= 1'b0;
      mtvec_q  <= {MTVEC_INIT[31:2], 2'b00};
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      meie_q   <= meie_d;
      mtip_q   <= bus.timer_irq;
      meip_q   <= bus.ext_irq;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end
`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic [63:0] cyc_n, ins_n;
  assign cyc64 = 64'(cyc_q);
  assign ins64 = 64'(ins_q);
  // a written half replaces that half's incremented value; truncation to CNT_W gives the wrap
  always_comb begin
    cyc_n = cyc64 + 64'd1;
    ins_n = ins64 + 64'(bus.retire & ~bus.stall & (state_q == RUN));
    if (csr_we && bus.csr_addr == 12'hB00) cyc_n[31:0]  = wval;
    if (csr_we && bus.csr_addr == 12'hB80) cyc_n[63:32] = wval;
    if (csr_we && bus.csr_addr == 12'hB02) ins_n[31:0]  = wval;
    if (csr_we && bus.csr_addr == 12'hB82) ins_n[63:32] = wval;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_n[CNT_W-1:0];
      ins_q <= ins_n[CNT_W-1:0];
    end
  end
`else
  assign cyc64 = '0;
  assign ins64 = '0;
`endif
endmodule

// File: tb/tb_csr_unit_m.sv
// tb_csr_unit_m: directed scoreboard bench for csr_unit_m.
module tb_csr_unit_m;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  csr_unit_m_if bus();
  csr_unit_m #(.CNT_W(40)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  typedef enum int {K_RDATA, K_REDIR, K_RPC, K_SLEEP} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  function automatic void push_exp(string name, kind_e k, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(logic [11:0] a, logic [31:0] v, string name);
    bus.csr_addr = a;
    bus.csr_op   = 2'b00;
    push_exp(name, K_RDATA, v);
    step();
  endtask
  task automatic wr(logic [11:0] a, logic [1:0] op, logic [31:0] d);
    bus.csr_addr  = a;
    bus.csr_op    = op;
    bus.csr_wdata = d;
    step();
    bus.csr_op = 2'b00;
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.kind == K_RDATA ? bus.csr_rdata :
            e.kind == K_REDIR ? {31'd0, bus.redirect} :
            e.kind == K_RPC   ? bus.redirect_pc : {31'd0, bus.sleeping};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end
  initial begin
    bus.csr_addr  = '0;
    bus.csr_wdata = '0;
    bus.csr_op    = 2'b00;
    bus.retire    = 1'b0;
    bus.stall     = 1'b0;
    bus.wfi       = 1'b0;
    bus.mret      = 1'b0;
    bus.trap_pc   = '0;
    bus.ext_irq   = 1'b0;
    bus.timer_irq = 1'b0;
    #1;
    bus.csr_addr = 12'h300;
    push_exp("rst_redirect", K_REDIR, 32'd0);
    push_exp("rst_redirect_pc", K_RPC, 32'h0001_0000);
    push_exp("rst_sleeping", K_SLEEP, 32'd0);
    push_exp("rst_mstatus", K_RDATA, 32'h0000_1800);
    step();
    step();
    rst_n = 1'b1;
    rd(12'h305, 32'h0001_0000, "mtvec_rst");
    rd(12'hB00, CNT_EN ? 32'd1 : 32'd0, "mcycle_first");
    rd(12'h341, 32'd0, "mepc_rst");
    rd(12'h342, 32'd0, "mcause_rst");
    rd(12'h304, 32'd0, "mie_rst");
    rd(12'h344, 32'd0, "mip_rst");
    wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
    rd(12'h7C0, 32'd0, "unmapped");
    wr(12'h305, 2'b01, 32'h0000_2000);
    rd(12'h305, 32'h0001_0000, "mtvec_readonly");
    wr(12'h341, 2'b01, 32'h0000_0123);
    rd(12'h341, 32'h0000_0120, "mepc_write");
    wr(12'h341, 2'b10, 32'h0000_0F00);
    rd(12'h341, 32'h0000_0F20, "mepc_set");
    wr(12'h341, 2'b11, 32'h0000_0020);
    rd(12'h341, 32'h0000_0F00, "mepc_clear");
    wr(12'h304, 2'b01, 32'h0000_0800);
    wr(12'h300, 2'b01, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_write");
    bus.ext_irq = 1'b1;
    bus.trap_pc = 32'h0000_0120;
    push_exp("irq_sample_cycle", K_REDIR, 32'd0);
    step();
    bus.ext_irq = 1'b0;
    push_exp("irq_redirect", K_REDIR, 32'd1);
    push_exp("irq_redirect_pc", K_RPC, 32'h0001_0000);
    step();
    rd(12'h341, 32'h0000_0120, "trap_mepc");
    rd(12'h342, 32'h8000_000B, "trap_mcause");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    bus.ext_irq   = 1'b1;
    bus.timer_irq = 1'b1;
    step();
    push_exp("mie_gates_take", K_REDIR, 32'd0);
    rd(12'h344, 32'h0000_0880, "mip_both");
    bus.ext_irq   = 1'b0;
    bus.timer_irq = 1'b0;
    step();
    bus.mret = 1'b1;
    push_exp("mret_redirect", K_REDIR, 32'd1);
    push_exp("mret_redirect_pc", K_RPC, 32'h0000_0120);
    step();
    bus.mret = 1'b0;
    rd(12'h300, 32'h0000_1888, "mret_mstatus");
    bus.ext_irq = 1'b1;
    bus.stall   = 1'b1;
    bus.trap_pc = 32'h0000_0207;
    step();
    push_exp("stall_holds_take", K_REDIR, 32'd0);
    step();
    bus.stall   = 1'b0;
    bus.ext_irq = 1'b0;
    push_exp("stall_release_redirect", K_REDIR, 32'd1);
    push_exp("stall_release_pc", K_RPC, 32'h0001_0000);
    step();
    rd(12'h341, 32'h0000_0204, "trap_pc_aligned");
    wr(12'h304, 2'b01, 32'h0000_0080);
    bus.wfi = 1'b1;
    step();
    bus.wfi = 1'b0;
    push_exp("wfi_sleeping", K_SLEEP, 32'd1);
    wr(12'h341, 2'b01, 32'h0000_AAA0);
    bus.timer_irq = 1'b1;
    push_exp("sleep_hold", K_SLEEP, 32'd1);
    step();
    push_exp("sleep_pend_cycle", K_SLEEP, 32'd1);
    push_exp("sleep_pend_noredirect", K_REDIR, 32'd0);
    step();
    push_exp("wake_running", K_SLEEP, 32'd0);
    push_exp("wake_noredirect", K_REDIR, 32'd0);
    step();
    bus.wfi = 1'b1;
    step();
    bus.wfi = 1'b0;
    push_exp("wfi_pending_nop", K_SLEEP, 32'd0);
    step();
    rd(12'h341, 32'h0000_0204, "sleep_write_ignored");
    wr(12'h300, 2'b10, 32'h0000_0008);
    bus.mret      = 1'b1;
    bus.csr_addr  = 12'h304;
    bus.csr_op    = 2'b01;
    bus.csr_wdata = 32'd0;
    bus.trap_pc   = 32'h0000_0300;
    push_exp("prio_redirect", K_REDIR, 32'd1);
    push_exp("prio_redirect_pc", K_RPC, 32'h0001_0000);
    step();
    bus.mret      = 1'b0;
    bus.csr_op    = 2'b00;
    bus.timer_irq = 1'b0;
    rd(12'h304, 32'h0000_0080, "prio_mie_kept");
    rd(12'h342, 32'h8000_0007, "prio_mcause");
    rd(12'h341, 32'h0000_0300, "prio_mepc");
    rd(12'h300, 32'h0000_1880, "prio_mstatus");
    wr(12'hB80, 2'b01, 32'd0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00, CNT_EN ? 32'hFFFF_FFFF : 32'd0, "mcycle_write");
    rd(12'hB80, CNT_EN ? 32'd1 : 32'd0, "mcycleh_carry");
    wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB80, CNT_EN ? 32'h0000_00FF : 32'd0, "mcycleh_cnt_w");
    bus.retire = 1'b1;
    wr(12'hB02, 2'b01, 32'd5);
    step();
    bus.stall = 1'b1;
    step();
    bus.stall  = 1'b0;
    bus.retire = 1'b0;
    rd(12'hB02, CNT_EN ? 32'd6 : 32'd0, "minstret");
    rd(12'hB82, 32'd0, "minstreth");
    bus.wfi = 1'b1;
    step();
    bus.wfi = 1'b0;
    push_exp("pre_reset_sleeping", K_SLEEP, 32'd1);
    step();
    rst_n = 1'b0;
    push_exp("async_reset_wakes", K_SLEEP, 32'd0);
    rd(12'h304, 32'd0, "async_reset_mie");
    rst_n = 1'b1;
    rd(12'h300, 32'h0000_1800, "post_reset_mstatus");
    repeat (2) step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
